// File: rtl/seq_det_pkg.sv
// Shared types and reset defaults for the parametrised serial pattern detector.
package seq_det_pkg;

  typedef enum logic {
    S_FILL  = 1'b0,
    S_ARMED = 1'b1
  } state_t;

  localparam int         DEF_MAX_LEN    = 8;
  localparam logic [7:0] DEF_PATTERN_C  = 8'b0000_1001;
  localparam int         DEF_LEN_C      = 4;
  localparam logic       DEF_OVERLAP_C  = 1'b0;
  localparam int         DEF_CNT_W      = 16;

  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/seq_det_cmp.sv
// Masked compare of the newest len bits ({hist, data_in}) against the pattern.
module seq_det_cmp
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = len_width(MAX_LEN)
) (
  input  logic [MAX_LEN-2:0] hist,
  input  logic               data_in,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               eq
);

  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] mask;

  // Only bit positions below len take part in the compare.
  always_comb begin
    window = {hist, data_in};
    mask   = {MAX_LEN{1'b0}};
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len));
    end
    eq = (((window ^ pattern) & mask) == {MAX_LEN{1'b0}});
  end

endmodule

// File: rtl/seq_det_param.sv
// Runtime-configurable serial pattern detector with Mealy match and registered copy.
// Optional saturating match counter enabled by defining SEQ_DET_COUNT_EN.
module seq_det_param
  import seq_det_pkg::*;
#(
  parameter int               MAX_LEN     = DEF_MAX_LEN,
  parameter int               LEN_W       = len_width(MAX_LEN),
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(DEF_PATTERN_C),
  parameter int               DEF_LEN     = DEF_LEN_C,
  parameter logic             DEF_OVERLAP = DEF_OVERLAP_C
`ifdef SEQ_DET_COUNT_EN
  , parameter int             CNT_W       = DEF_CNT_W
`endif
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               data_valid,
  input  logic               data_in,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               cfg_err,
  output logic               match,
  output logic               match_r
`ifdef SEQ_DET_COUNT_EN
  , output logic [CNT_W-1:0] match_count,
  input  logic               count_clr
`endif
);

  // The oldest of MAX_LEN bits is never compared, so history keeps MAX_LEN-1 bits.
  logic [MAX_LEN-2:0] hist, hist_next;
  logic [LEN_W-1:0]   fill, fill_next, fill_inc;
  logic [MAX_LEN-1:0] pattern, pattern_next;
  logic [LEN_W-1:0]   len, len_next;
  logic               overlap, overlap_next;
  state_t             state, state_next;
  logic [MAX_LEN-1:0] window;
  logic               cfg_ok, cfg_bad, eq, match_s;

  seq_det_cmp #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_cmp (
    .hist    (hist),
    .data_in (data_in),
    .pattern (pattern),
    .len     (len),
    .eq      (eq)
  );

  // Next-state, history, configuration and Mealy match decode.
  always_comb begin
    window       = {hist, data_in};
    cfg_ok       = cfg_load && (cfg_len != {LEN_W{1'b0}}) && (cfg_len <= LEN_W'(MAX_LEN));
    cfg_bad      = cfg_load && !cfg_ok;
    match_s      = reset_n && data_valid && !cfg_ok && (state == S_ARMED) && eq;
    fill_inc     = (fill < len) ? (fill + LEN_W'(1)) : fill;
    hist_next    = hist;
    fill_next    = fill;
    pattern_next = pattern;
    len_next     = len;
    overlap_next = overlap;
    state_next   = state;
    if (cfg_ok) begin
      pattern_next = cfg_pattern;
      len_next     = cfg_len;
      overlap_next = cfg_overlap;
      hist_next    = {(MAX_LEN-1){1'b0}};
      fill_next    = {LEN_W{1'b0}};
      state_next   = (cfg_len == LEN_W'(1)) ? S_ARMED : S_FILL;
    end else if (data_valid) begin
      if (match_s && !overlap) begin
        hist_next  = {(MAX_LEN-1){1'b0}};
        fill_next  = {LEN_W{1'b0}};
        state_next = (len == LEN_W'(1)) ? S_ARMED : S_FILL;
      end else begin
        hist_next = window[MAX_LEN-2:0];
        fill_next = fill_inc;
        case (state)
          S_FILL:  state_next = (fill_inc >= (len - LEN_W'(1))) ? S_ARMED : S_FILL;
          S_ARMED: state_next = S_ARMED;
          default: state_next = S_FILL;
        endcase
      end
    end else begin
      state_next = state;
    end
    match = match_s;
  end

  // State, history, configuration and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hist    <= {(MAX_LEN-1){1'b0}};
      fill    <= {LEN_W{1'b0}};
      pattern <= DEF_PATTERN;
      len     <= LEN_W'(DEF_LEN);
      overlap <= DEF_OVERLAP;
      state   <= (DEF_LEN == 1) ? S_ARMED : S_FILL;
      match_r <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      hist    <= hist_next;
      fill    <= fill_next;
      pattern <= pattern_next;
      len     <= len_next;
      overlap <= overlap_next;
      state   <= state_next;
      match_r <= match_s;
      cfg_err <= cfg_bad;
    end
  end

`ifdef SEQ_DET_COUNT_EN
  // Saturating match counter; a clear coinciding with a match leaves one counted.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      match_count <= {CNT_W{1'b0}};
    end else if (count_clr) begin
      match_count <= match_s ? CNT_W'(1) : {CNT_W{1'b0}};
    end else if (match_s && (match_count != {CNT_W{1'b1}})) begin
      match_count <= match_count + CNT_W'(1);
    end else begin
      match_count <= match_count;
    end
  end
`endif

endmodule

// File: tb/tb_seq_det_param.sv
// Randomised and directed bench for seq_det_param against a queue-based pattern model.
// Counter checks are compiled in when SEQ_DET_COUNT_EN is defined.
module tb_seq_det_param;

  localparam int MAX_LEN  = 8;
  localparam int LEN_W    = 4;
  localparam int TB_CNT_W = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic data_valid = 1'b0;
  logic data_in = 1'b0;
  logic cfg_load = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = 8'h00;
  logic [LEN_W-1:0] cfg_len = 4'd0;
  logic cfg_overlap = 1'b0;
  logic count_clr = 1'b0;
  logic cfg_err, match, match_r;
  logic [TB_CNT_W-1:0] match_count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: received bits since the last clear, plus configuration.
  logic       m_q[$];
  logic [7:0] m_pat = 8'b0000_1001;
  int         m_len = 4;
  logic       m_ovl = 1'b0;
  logic       m_prev = 1'b0;
  logic       m_err = 1'b0;
  int         m_count = 0;

`ifdef SEQ_DET_COUNT_EN
  seq_det_param #(.CNT_W(TB_CNT_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .data_valid  (data_valid),
    .data_in     (data_in),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_err     (cfg_err),
    .match       (match),
    .match_r     (match_r),
    .match_count (match_count),
    .count_clr   (count_clr)
  );
`else
  seq_det_param dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .data_valid  (data_valid),
    .data_in     (data_in),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_err     (cfg_err),
    .match       (match),
    .match_r     (match_r)
  );

  assign match_count = '0;
`endif

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_match(input logic rst, input logic v, input logic d, input logic legal);
    logic b;
    if (!rst || legal || !v) return 1'b0;
    if (m_q.size() + 1 < m_len) return 1'b0;
    for (int k = 0; k < m_len; k++) begin
      b = (k == 0) ? d : m_q[m_q.size() - k];
      if (b !== m_pat[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic cyc(input logic rst, input logic v, input logic d, input logic ld,
                     input logic [7:0] pat, input logic [3:0] ln, input logic ov, input logic clr);
    logic legal, exp_m;
    @(negedge clk);
    reset_n = rst; data_valid = v; data_in = d; cfg_load = ld;
    cfg_pattern = pat; cfg_len = ln; cfg_overlap = ov; count_clr = clr;
    #1;
    legal = ld && (ln >= 4'd1) && (ln <= 4'd8);
    exp_m = model_match(rst, v, d, legal);
    check_eq("match", {31'd0, match}, {31'd0, exp_m});
    check_eq("match_r", {31'd0, match_r}, {31'd0, m_prev});
    check_eq("cfg_err", {31'd0, cfg_err}, {31'd0, m_err});
`ifdef SEQ_DET_COUNT_EN
    check_eq("match_count", {24'd0, match_count}, m_count);
`endif
    if (!rst) begin
      m_q.delete();
      m_pat = 8'b0000_1001; m_len = 4; m_ovl = 1'b0;
      m_prev = 1'b0; m_err = 1'b0; m_count = 0;
    end else begin
      if (legal) begin
        m_pat = pat; m_len = int'(ln); m_ovl = ov;
        m_q.delete();
      end else if (v) begin
        if (exp_m && !m_ovl) begin
          m_q.delete();
        end else begin
          m_q.push_back(d);
          if (m_q.size() > MAX_LEN) void'(m_q.pop_front());
        end
      end
      m_prev = exp_m;
      m_err  = ld && !legal;
      if (clr) m_count = exp_m ? 1 : 0;
      else if (exp_m && m_count < (1 << TB_CNT_W) - 1) m_count++;
    end
  endtask

  task automatic bit_in(input logic d);
    cyc(1'b1, 1'b1, d, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [7:0] pat, input logic [3:0] ln, input logic ov);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, pat, ln, ov, 1'b0);
  endtask

  initial begin
    logic [6:0] s7;
    logic [3:0] s4;
    s7 = 7'b1001001;
    s4 = 4'b1011;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
    // Default 1001 non-overlap, then overlap reloaded.
    for (int i = 6; i >= 0; i--) bit_in(s7[i]);
    idle();
    load(8'b0000_1001, 4'd4, 1'b1);
    for (int i = 6; i >= 0; i--) bit_in(s7[i]);
    idle();
    // Valid gaps are transparent.
    load(8'b0000_1001, 4'd4, 1'b0);
    bit_in(1'b1); bit_in(1'b0);
    idle(); idle(); idle();
    bit_in(1'b0); bit_in(1'b1);
    idle();
    // Illegal lengths rejected while detection continues.
    bit_in(1'b1); bit_in(1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 8'hff, 4'd0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'hff, 4'd9, 1'b1, 1'b0);
    idle(); idle();
    // Single-bit pattern.
    load(8'b0000_0001, 4'd1, 1'b0);
    for (int i = 3; i >= 0; i--) bit_in(s4[i]);
    idle();
    // Reset mid-pattern discards history.
    load(8'b0000_1001, 4'd4, 1'b0);
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 4'd1, 1'b1, 1'b0);
    bit_in(1'b1);
    idle();
`ifdef SEQ_DET_COUNT_EN
    load(8'b0000_0001, 4'd1, 1'b1);
    for (int i = 0; i < (1 << TB_CNT_W) + 4; i++) bit_in(1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1);
    idle();
`endif
    // Randomised traffic with short patterns so matches are frequent.
    for (int n = 0; n < 3000; n++) begin
      logic rst, v, d, ld, ov, clr;
      logic [7:0] pat;
      logic [3:0] ln;
      rst = ($urandom_range(0, 199) != 0);
      v   = ($urandom_range(0, 3) != 0);
      d   = 1'($urandom_range(0, 1));
      ld  = ($urandom_range(0, 39) == 0);
      pat = 8'($urandom);
      ln  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 3));
      ov  = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 63) == 0);
      cyc(rst, v, d, ld, pat, ln, ov, clr);
    end
    idle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
